// File: rtl/ctrl_pipe_pkg.sv
// Opcode/funct/rt encodings and control-word layout for the MIPS control pipeline.
// Also the destination-register rule that is shared by the decoder.
package ctrl_pipe_pkg;

    localparam int CTRL_BASE_W = 13;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FUN_SLL  = 6'h00;
    localparam logic [5:0] FUN_SRL  = 6'h02;
    localparam logic [5:0] FUN_SRA  = 6'h03;
    localparam logic [5:0] FUN_JR   = 6'h08;
    localparam logic [5:0] FUN_JALR = 6'h09;
    localparam logic [5:0] FUN_MTHI = 6'h11;
    localparam logic [5:0] FUN_MTLO = 6'h13;

    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    localparam int CTRL_JUMP      = 0;
    localparam int CTRL_MEMTOREG  = 1;
    localparam int CTRL_MEMWRITE  = 2;
    localparam int CTRL_BRANCH    = 3;
    localparam int CTRL_ALUSRCB   = 4;
    localparam int CTRL_REGDST    = 5;
    localparam int CTRL_REGWRITE  = 6;
    localparam int CTRL_ALUSRCA   = 7;
    localparam int CTRL_JAL       = 8;
    localparam int CTRL_JR        = 9;
    localparam int CTRL_BAL       = 10;
    localparam int CTRL_HILOWRITE = 11;
    localparam int CTRL_RI        = 12;

    localparam logic [12:0] CTRL_BUBBLE = 13'h000;
    localparam logic [12:0] CW_SHIFT    = 13'h0E0;
    localparam logic [12:0] CW_JR       = 13'h201;
    localparam logic [12:0] CW_JALR     = 13'h260;
    localparam logic [12:0] CW_HILO     = 13'h800;
    localparam logic [12:0] CW_RTYPE    = 13'h060;
    localparam logic [12:0] CW_LOAD     = 13'h052;
    localparam logic [12:0] CW_STORE    = 13'h016;
    localparam logic [12:0] CW_IMM      = 13'h050;
    localparam logic [12:0] CW_BRANCH   = 13'h008;
    localparam logic [12:0] CW_BAL      = 13'h448;
    localparam logic [12:0] CW_J        = 13'h001;
    localparam logic [12:0] CW_JAL      = 13'h140;
    localparam logic [12:0] CW_RI       = 13'h1000;

    function automatic logic [4:0] dest_reg(input logic [12:0] c, input logic [31:0] instr);
        if (!c[CTRL_REGWRITE])                 return 5'd0;
        else if (c[CTRL_JAL] || c[CTRL_BAL])   return 5'd31;
        else if (c[CTRL_REGDST])               return instr[15:11];
        else                                   return instr[20:16];
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline register with reset > flush > stall(hold) > bubble > load priority.
module ctrl_stage_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         stall,
    input  logic         bubble_in,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = d;
        if (flush)          q_d = '0;
        else if (stall)     q_d = q_q;
        else if (bubble_in) q_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/ctrl_pipe.sv
// MIPS control decode plus NSTAGES of control/dest/valid pipeline registers,
// with per-stage stall/flush, bubble insertion and load-use detection.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int CTRL_W  = 13,
    parameter int NSTAGES = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               instrD,
    input  logic                      validD,
    input  logic [NSTAGES-1:0]        stall,
    input  logic [NSTAGES-1:0]        flush,
    output logic [CTRL_W-1:0]         ctrlD,
    output logic                      riD,
    output logic [NSTAGES*CTRL_W-1:0] ctrl_q,
    output logic [NSTAGES*5-1:0]      dst_q,
    output logic [NSTAGES-1:0]        valid_q,
    output logic                      lu_stall
);

    localparam int SW = CTRL_W + 6;

    logic [12:0] dec;
    logic [4:0]  dstD;
    logic        unused_shamt;

    assign unused_shamt = ^instrD[10:6];

    always_comb begin
        dec = CW_RI;
        unique case (instrD[31:26])
            OP_RTYPE: begin
                unique case (instrD[5:0])
                    FUN_SLL, FUN_SRL, FUN_SRA: dec = CW_SHIFT;
                    FUN_JR:                    dec = CW_JR;
                    FUN_JALR:                  dec = CW_JALR;
                    FUN_MTHI, FUN_MTLO:        dec = CW_HILO;
                    default:                   dec = CW_RTYPE;
                endcase
            end
            OP_REGIMM: begin
                unique case (instrD[20:16])
                    RT_BLTZ, RT_BGEZ:     dec = CW_BRANCH;
                    RT_BLTZAL, RT_BGEZAL: dec = CW_BAL;
                    default:              dec = CW_RI;
                endcase
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: dec = CW_LOAD;
            OP_SB, OP_SH, OP_SW:                 dec = CW_STORE;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI:    dec = CW_IMM;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:    dec = CW_BRANCH;
            OP_J:                                dec = CW_J;
            OP_JAL:                              dec = CW_JAL;
            default:                             dec = CW_RI;
        endcase
    end

    always_comb begin
        ctrlD       = '0;
        ctrlD[12:0] = dec;
    end

    assign riD  = dec[CTRL_RI];
    assign dstD = dest_reg(dec, instrD);

    // stg[0] is the D-side input; stg[k+1] is the output of stage k
    logic [NSTAGES:0][SW-1:0] stg;
    logic [NSTAGES-1:0]       bub;

    assign stg[0] = {ctrlD, dstD, validD};

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign bub[k] = ~validD;
        end else begin : g_rest
            // upstream stalled but we move on: take a bubble, not a duplicate
            assign bub[k] = stall[k-1];
        end

        ctrl_stage_reg #(.W(SW)) u_reg (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush[k]),
            .stall    (stall[k]),
            .bubble_in(bub[k]),
            .d        (stg[k]),
            .q        (stg[k+1])
        );

        assign ctrl_q[k*CTRL_W +: CTRL_W] = stg[k+1][SW-1:6];
        assign dst_q[k*5 +: 5]            = stg[k+1][5:1];
        assign valid_q[k]                 = stg[k+1][0];
    end

    assign lu_stall = stg[1][0] & stg[1][6+CTRL_MEMTOREG] & stg[1][6+CTRL_REGWRITE]
                    & (stg[1][5:1] != 5'd0) & validD
                    & ((stg[1][5:1] == instrD[25:21]) | (stg[1][5:1] == instrD[20:16]));

endmodule

// File: tb/tb_ctrl_pipe.sv
// Randomized + directed bench for ctrl_pipe at default size and at NSTAGES=5, CTRL_W=16.
module tb_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instrD;
    logic        validD;
    logic [4:0]  stall5, flush5;

    logic [12:0] ctrlD_a;
    logic        riD_a, lu_a;
    logic [38:0] ctrl_q_a;
    logic [14:0] dst_q_a;
    logic [2:0]  valid_q_a;

    logic [15:0] ctrlD_b;
    logic        riD_b, lu_b;
    logic [79:0] ctrl_q_b;
    logic [24:0] dst_q_b;
    logic [4:0]  valid_q_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ctrl_pipe u_a (
        .clk(clk), .rst(rst), .instrD(instrD), .validD(validD),
        .stall(stall5[2:0]), .flush(flush5[2:0]),
        .ctrlD(ctrlD_a), .riD(riD_a), .ctrl_q(ctrl_q_a), .dst_q(dst_q_a),
        .valid_q(valid_q_a), .lu_stall(lu_a)
    );

    ctrl_pipe #(.CTRL_W(16), .NSTAGES(5)) u_b (
        .clk(clk), .rst(rst), .instrD(instrD), .validD(validD),
        .stall(stall5), .flush(flush5),
        .ctrlD(ctrlD_b), .riD(riD_b), .ctrl_q(ctrl_q_b), .dst_q(dst_q_b),
        .valid_q(valid_q_b), .lu_stall(lu_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference decode straight from the instruction-class table
    function automatic logic [15:0] ref_dec(input logic [31:0] i);
        logic [5:0] op, fn;
        logic [4:0] rt;
        op = i[31:26]; fn = i[5:0]; rt = i[20:16];
        if (op == 6'h00) begin
            if (fn inside {6'h00, 6'h02, 6'h03}) return 16'h0E0;
            if (fn == 6'h08)                     return 16'h201;
            if (fn == 6'h09)                     return 16'h260;
            if (fn inside {6'h11, 6'h13})        return 16'h800;
            return 16'h060;
        end
        if (op == 6'h01) begin
            if (rt inside {5'h00, 5'h01}) return 16'h008;
            if (rt inside {5'h10, 5'h11}) return 16'h448;
            return 16'h1000;
        end
        if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) return 16'h052;
        if (op inside {6'h28, 6'h29, 6'h2B})               return 16'h016;
        if (op >= 6'h08 && op <= 6'h0F)                    return 16'h050;
        if (op >= 6'h04 && op <= 6'h07)                    return 16'h008;
        if (op == 6'h02)                                   return 16'h001;
        if (op == 6'h03)                                   return 16'h140;
        return 16'h1000;
    endfunction

    function automatic logic [4:0] ref_dst(input logic [15:0] w, input logic [31:0] i);
        if (!w[6])         return 5'd0;
        if (w[8] || w[10]) return 5'd31;
        if (w[5])          return i[15:11];
        return i[20:16];
    endfunction

    typedef struct {
        logic [15:0] c;
        logic [4:0]  d;
        logic        v;
    } ent_t;

    ent_t m [2][5];
    int   ns [2] = '{3, 5};

    task automatic model_clear();
        for (int u = 0; u < 2; u++)
            for (int k = 0; k < 5; k++) m[u][k] = '{c: 16'h0, d: 5'h0, v: 1'b0};
    endtask

    task automatic model_step();
        ent_t old [5];
        ent_t inD, zero;
        zero = '{c: 16'h0, d: 5'h0, v: 1'b0};
        inD.c = ref_dec(instrD);
        inD.d = ref_dst(inD.c, instrD);
        inD.v = validD;
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 5; k++) old[k] = m[u][k];
            for (int k = 0; k < ns[u]; k++) begin
                if (rst)                                    m[u][k] = zero;
                else if (flush5[k])                         m[u][k] = zero;
                else if (stall5[k])                         m[u][k] = old[k];
                else if (k == 0 && !validD)                 m[u][k] = zero;
                else if (k > 0 && stall5[k-1])              m[u][k] = zero;
                else                                        m[u][k] = (k == 0) ? inD : old[k-1];
            end
        end
    endtask

    function automatic logic ref_lu(input int u);
        ent_t e;
        e = m[u][0];
        return e.v && e.c[1] && e.c[6] && e.d != 0 && validD &&
               (e.d == instrD[25:21] || e.d == instrD[20:16]);
    endfunction

    task automatic drive(input logic [31:0] ins, input logic v, input logic r,
                         input logic [4:0] st, input logic [4:0] fl);
        @(negedge clk);
        instrD = ins; validD = v; rst = r; stall5 = st; flush5 = fl;
        #1;
        chk("a_ctrlD", ctrlD_a, ref_dec(ins));
        chk("b_ctrlD", ctrlD_b, ref_dec(ins));
        chk("a_riD", riD_a, ref_dec(ins) == 16'h1000);
        chk("b_riD", riD_b, ref_dec(ins) == 16'h1000);
        chk("a_lu", lu_a, ref_lu(0));
        chk("b_lu", lu_b, ref_lu(1));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("a_ctrl%0d", k), ctrl_q_a[k*13 +: 13], m[0][k].c);
            chk($sformatf("a_dst%0d", k), dst_q_a[k*5 +: 5], m[0][k].d);
            chk($sformatf("a_vld%0d", k), valid_q_a[k], m[0][k].v);
        end
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("b_ctrl%0d", k), ctrl_q_b[k*16 +: 16], m[1][k].c);
            chk($sformatf("b_dst%0d", k), dst_q_b[k*5 +: 5], m[1][k].d);
            chk($sformatf("b_vld%0d", k), valid_q_b[k], m[1][k].v);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [24] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                                 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
        logic [5:0] fns [8] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h11, 6'h13, 6'h20};
        logic [4:0] rts [5] = '{5'h00, 5'h01, 5'h10, 5'h11, 5'h07};
        logic [31:0] i;
        i = $urandom;
        // small register numbers so load-use matches happen often
        i[25:21] = 5'($urandom_range(0, 3));
        i[15:11] = 5'($urandom_range(0, 3));
        i[20:16] = 5'($urandom_range(0, 3));
        if ($urandom_range(0, 9) != 0) i[31:26] = ops[$urandom_range(0, 23)];
        if (i[31:26] == 6'h00) i[5:0] = fns[$urandom_range(0, 7)];
        if (i[31:26] == 6'h01) i[20:16] = rts[$urandom_range(0, 4)];
        return i;
    endfunction

    localparam logic [31:0] I_LW   = 32'h8C080004;
    localparam logic [31:0] I_ADD  = 32'h01084820;
    localparam logic [31:0] I_LW0  = 32'h8C000004;
    localparam logic [31:0] I_ADD0 = 32'h00004820;
    localparam logic [31:0] I_JAL  = 32'h0C000010;
    localparam logic [31:0] I_RI   = 32'hFC000000;

    initial begin
        rst = 1'b1; instrD = '0; validD = 1'b0; stall5 = '0; flush5 = '0;
        model_clear();

        drive(32'h0, 1'b0, 1'b1, 5'h0, 5'h0); step();
        drive(32'h0, 1'b0, 1'b1, 5'h0, 5'h0); step();
        chk("rst_ctrl_a", ctrl_q_a, 39'h0);
        chk("rst_dst_a", dst_q_a, 15'h0);
        chk("rst_vld_a", valid_q_a, 3'b000);
        chk("rst_vld_b", valid_q_b, 5'b00000);

        drive(I_LW, 1'b1, 1'b0, 5'h0, 5'h0);
        chk("lw_ctrlD", ctrlD_a, 13'h052);
        step();
        chk("lw_E_ctrl", ctrl_q_a[12:0], 13'h052);
        chk("lw_E_dst", dst_q_a[4:0], 5'd8);
        chk("lw_E_vld", valid_q_a, 3'b001);

        drive(I_ADD, 1'b1, 1'b0, 5'h0, 5'h0);
        chk("lu_hit_a", lu_a, 1'b1);
        chk("lu_hit_b", lu_b, 1'b1);
        step();
        drive(32'h0, 1'b0, 1'b0, 5'h0, 5'h0); step();
        chk("lw_W_ctrl", ctrl_q_a[38:26], 13'h052);
        chk("lw_W_dst", dst_q_a[14:10], 5'd8);
        chk("lw_W_vld", valid_q_a[2], 1'b1);

        drive(I_LW0, 1'b1, 1'b0, 5'h0, 5'h0); step();
        drive(I_ADD0, 1'b1, 1'b0, 5'h0, 5'h0);
        chk("lu_dst0", lu_a, 1'b0);
        step();

        drive(I_LW, 1'b1, 1'b0, 5'h0, 5'h0); step();
        for (int n = 0; n < 2; n++) begin
            drive(I_ADD, 1'b1, 1'b0, 5'b00001, 5'h0); step();
            chk("stall_E_hold", ctrl_q_a[12:0], 13'h052);
            chk("stall_M_bub", valid_q_a[1], 1'b0);
        end
        drive(I_ADD, 1'b1, 1'b0, 5'b00001, 5'b00001); step();
        chk("flush_win_ctrl", ctrl_q_a[12:0], 13'h0);
        chk("flush_win_vld", valid_q_a[0], 1'b0);

        drive(I_JAL, 1'b1, 1'b0, 5'h0, 5'h0);
        chk("jal_ctrlD", ctrlD_a, 13'h140);
        step();
        chk("jal_dst", dst_q_a[4:0], 5'd31);

        drive(I_RI, 1'b1, 1'b0, 5'h0, 5'h0);
        chk("ri_riD", riD_a, 1'b1);
        chk("ri_bit12", ctrlD_a[12], 1'b1);
        step();
        drive(32'h0, 1'b0, 1'b0, 5'h0, 5'h0); step();
        chk("ri_at_M_a", ctrl_q_a[25], 1'b1);
        chk("ri_at_M_b", ctrl_q_b[28], 1'b1);

        for (int n = 0; n < 5; n++) begin
            drive(I_LW, 1'b1, 1'b0, 5'h0, 5'h0); step();
        end
        chk("full_vld_a", valid_q_a, 3'b111);
        drive(I_LW, 1'b1, 1'b1, 5'h1F, 5'h0); step();
        chk("midrst_ctrl_a", ctrl_q_a, 39'h0);
        chk("midrst_dst_a", dst_q_a, 15'h0);
        chk("midrst_vld_a", valid_q_a, 3'b000);
        chk("midrst_ctrl_b", ctrl_q_b, 80'h0);
        chk("midrst_dst_b", dst_q_b, 25'h0);
        chk("midrst_vld_b", valid_q_b, 5'b00000);

        for (int n = 0; n < 600; n++) begin
            logic [4:0] st, fl;
            for (int k = 0; k < 5; k++) begin
                st[k] = ($urandom_range(0, 5) == 0);
                fl[k] = ($urandom_range(0, 9) == 0);
            end
            drive(rand_instr(), $urandom_range(0, 4) != 0, $urandom_range(0, 49) == 0, st, fl);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
